// File: rtl/vend_controller.sv
module vend_controller #(
    parameter int BAL_W       = 10,
    parameter int COIN_W      = 7,
    parameter int N_ITEMS     = 4,
    parameter int SEL_W       = 2,
    parameter logic [N_ITEMS*BAL_W-1:0] PRICES = {10'd200, 10'd150, 10'd100, 10'd175},
    parameter int MAX_BAL     = 500,
    parameter int CHANGE_UNIT = 25,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [COIN_W-1:0] money_in,
    input  logic              money_valid,
    input  logic [SEL_W-1:0]  item_sel,
    input  logic              purchase,
    input  logic              coin_return,
    input  logic              coin_ready,
    output logic              coin_valid,
    output logic [BAL_W-1:0]  coin_amount,
    output logic [BAL_W-1:0]  balance,
    output logic              approved,
    output logic [SEL_W-1:0]  vend_item,
    output logic              denied,
    output logic              rejected,
`ifdef VEND_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              busy
);

    typedef enum logic {IDLE, DISPENSE} state_t;

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   price, eff, after, bal_d, amt_d;
    logic [BAL_W:0]     sum;
    logic               item_ok, coin_ok, buy_ok, go_disp, tmo_hit;
    logic               cv_d, appr_d, den_d, rej_d, busy_d;
    logic [SEL_W-1:0]   vi_d;

    function automatic logic [BAL_W-1:0] chunk(input logic [BAL_W-1:0] b);
        return (b > BAL_W'(CHANGE_UNIT)) ? BAL_W'(CHANGE_UNIT) : b;
    endfunction

    always_comb begin
        price   = '0;
        item_ok = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (int'(item_sel) == i) begin
                price   = PRICES[i*BAL_W +: BAL_W];
                item_ok = 1'b1;
            end
        end
    end

    always_comb begin
        sum     = {1'b0, balance} + (BAL_W+1)'(money_in);
        coin_ok = sum <= (BAL_W+1)'(MAX_BAL);
        eff     = (money_valid && coin_ok) ? sum[BAL_W-1:0] : balance;
        buy_ok  = purchase && item_ok && (eff >= price);
        after   = buy_ok ? eff - price : eff;
        go_disp = (after != '0) && (buy_ok || coin_return || tmo_hit);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_arm;

    assign tmo_arm = (state_q == IDLE) && (balance != '0) &&
                     !money_valid && !purchase && !coin_return;
    assign tmo_hit = tmo_arm && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            tmo_cnt <= (tmo_arm && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
            timeout <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            balance     <= '0;
            coin_valid  <= 1'b0;
            coin_amount <= '0;
            approved    <= 1'b0;
            vend_item   <= '0;
            denied      <= 1'b0;
            rejected    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            balance     <= bal_d;
            coin_valid  <= cv_d;
            coin_amount <= amt_d;
            approved    <= appr_d;
            vend_item   <= vi_d;
            denied      <= den_d;
            rejected    <= rej_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (go_disp) state_d = DISPENSE;
            DISPENSE: if (coin_valid && coin_ready && balance == coin_amount) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bal_d  = balance;
        cv_d   = coin_valid;
        amt_d  = coin_amount;
        appr_d = 1'b0;
        den_d  = 1'b0;
        rej_d  = 1'b0;
        vi_d   = vend_item;
        busy_d = (state_d == DISPENSE);
        case (state_q)
            IDLE: begin
                rej_d  = money_valid && !coin_ok;
                bal_d  = after;
                appr_d = buy_ok;
                den_d  = purchase && !buy_ok;
                if (buy_ok) vi_d = item_sel;
                if (go_disp) begin
                    cv_d  = 1'b1;
                    amt_d = chunk(after);
                end
            end
            DISPENSE: begin
                rej_d = money_valid;
                if (coin_valid && coin_ready) begin
                    bal_d = balance - coin_amount;
                    if (bal_d == '0) cv_d = 1'b0;
                    else             amt_d = chunk(bal_d);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vend_controller.sv
module tb_vend_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  money_in = '0;
    logic        money_valid = 1'b0;
    logic [1:0]  item_sel = '0;
    logic        purchase = 1'b0;
    logic        coin_return = 1'b0;
    logic        coin_ready = 1'b0;
    logic        coin_valid;
    logic [9:0]  coin_amount;
    logic [9:0]  balance;
    logic        approved;
    logic [1:0]  vend_item;
    logic        denied;
    logic        rejected;
    logic        busy;
`ifdef VEND_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int errors = 0;

    vend_controller #(.TIMEOUT_CYC(8)) dut (
        .clock(clock), .reset(reset),
        .money_in(money_in), .money_valid(money_valid),
        .item_sel(item_sel), .purchase(purchase),
        .coin_return(coin_return), .coin_ready(coin_ready),
        .coin_valid(coin_valid), .coin_amount(coin_amount),
        .balance(balance), .approved(approved), .vend_item(vend_item),
        .denied(denied), .rejected(rejected),
`ifdef VEND_TIMEOUT_EN
        .timeout(timeout),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [6:0] v);
        money_valid = 1'b1;
        money_in    = v;
        tick();
        money_valid = 1'b0;
        money_in    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_balance", balance, 0);
        chk("rst_coin_valid", coin_valid, 0);
        chk("rst_coin_amount", coin_amount, 0);
        chk("rst_approved", approved, 0);
        chk("rst_vend_item", vend_item, 0);
        chk("rst_denied", denied, 0);
        chk("rst_rejected", rejected, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        coin(100);
        chk("t1_bal100", balance, 100);
        coin(100);
        chk("t1_bal200", balance, 200);
        purchase = 1'b1; item_sel = 2'd0;
        tick();
        purchase = 1'b0;
        chk("t1_approved", approved, 1);
        chk("t1_vend_item", vend_item, 0);
        chk("t1_balance", balance, 25);
        chk("t1_coin_valid", coin_valid, 1);
        chk("t1_coin_amount", coin_amount, 25);
        chk("t1_busy", busy, 1);
        coin_ready = 1'b1;
        tick();
        coin_ready = 1'b0;
        chk("t1_paid_bal", balance, 0);
        chk("t1_paid_cv", coin_valid, 0);
        chk("t1_paid_busy", busy, 0);
        chk("t1_appr_pulse", approved, 0);

        coin(100);
        purchase = 1'b1; item_sel = 2'd3;
        tick();
        purchase = 1'b0;
        chk("t2_denied", denied, 1);
        chk("t2_approved", approved, 0);
        chk("t2_balance", balance, 100);
        chk("t2_cv", coin_valid, 0);
        tick();
        chk("t2_denied_pulse", denied, 0);

        purchase = 1'b1; item_sel = 2'd1;
        tick();
        purchase = 1'b0;
        chk("t3_approved", approved, 1);
        chk("t3_vend_item", vend_item, 1);
        chk("t3_balance", balance, 0);
        chk("t3_busy", busy, 0);

        coin(60);
        chk("t3_bal60", balance, 60);
        coin_return = 1'b1; coin_ready = 1'b1;
        tick();
        coin_return = 1'b0;
        chk("t3_cv", coin_valid, 1);
        chk("t3_amt0", coin_amount, 25);
        chk("t3_bal0", balance, 60);
        tick();
        chk("t3_amt1", coin_amount, 25);
        chk("t3_bal1", balance, 35);
        tick();
        chk("t3_amt2", coin_amount, 10);
        chk("t3_bal2", balance, 10);
        tick();
        chk("t3_done_cv", coin_valid, 0);
        chk("t3_done_busy", busy, 0);
        chk("t3_done_bal", balance, 0);
        coin_return = 1'b1;
        tick();
        coin_return = 1'b0;
        chk("t3_empty_ret_busy", busy, 0);
        chk("t3_empty_ret_cv", coin_valid, 0);
        coin_ready = 1'b0;

        for (int i = 0; i < 4; i++) coin(100);
        coin(50);
        chk("t4_bal450", balance, 450);
        coin(100);
        chk("t4_rejected", rejected, 1);
        chk("t4_bal_kept", balance, 450);
        coin(50);
        chk("t4_rej_pulse", rejected, 0);
        chk("t4_bal500", balance, 500);
        coin_return = 1'b1;
        tick();
        coin_return = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_stall_cv", coin_valid, 1);
            chk("t4_stall_amt", coin_amount, 25);
            chk("t4_stall_bal", balance, 500);
        end
        coin(25);
        chk("t4_disp_rejected", rejected, 1);
        chk("t4_disp_bal", balance, 500);
        purchase = 1'b1; item_sel = 2'd1;
        tick();
        purchase = 1'b0;
        chk("t4_disp_no_buy", approved, 0);
        chk("t4_disp_no_buy_bal", balance, 500);
        coin_ready = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        chk("t4_last_bal", balance, 25);
        chk("t4_last_cv", coin_valid, 1);
        tick();
        coin_ready = 1'b0;
        chk("t4_drain_bal", balance, 0);
        chk("t4_drain_cv", coin_valid, 0);
        chk("t4_drain_busy", busy, 0);

        money_valid = 1'b1; money_in = 7'd100;
        purchase = 1'b1; item_sel = 2'd1;
        tick();
        money_valid = 1'b0; money_in = '0; purchase = 1'b0;
        chk("t5_approved", approved, 1);
        chk("t5_balance", balance, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cv", coin_valid, 0);

        coin(50);
        coin_return = 1'b1;
        tick();
        coin_return = 1'b0;
        chk("t6_pre_cv", coin_valid, 1);
        chk("t6_pre_bal", balance, 50);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_cv", coin_valid, 0);
        chk("t6_rst_bal", balance, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_post_cv", coin_valid, 0);

`ifdef VEND_TIMEOUT_EN
        coin(30);
        for (int i = 0; i < 7; i++) tick();
        chk("t7_no_timeout", timeout, 0);
        tick();
        chk("t7_timeout", timeout, 1);
        chk("t7_amt0", coin_amount, 25);
        coin_ready = 1'b1;
        tick();
        chk("t7_amt1", coin_amount, 5);
        tick();
        coin_ready = 1'b0;
        chk("t7_done", coin_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
